// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam int unsigned StrbUnit            = 8;
    localparam int unsigned DefaultMaxDataBurst = 4;

    function automatic int unsigned strb_width(int unsigned data_width);
        return data_width / StrbUnit;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-command signals of the shared memory port.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import mem_arb_pkg::*;

    localparam int unsigned StrbWidth = strb_width(DATA_WIDTH);

    logic                  if_valid;
    logic                  if_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_valid;
    logic                  d_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [StrbWidth-1:0]  d_wstrb;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [StrbWidth-1:0]  mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_valid, if_addr, d_valid, d_addr, d_we, d_wdata, d_wstrb, mem_rdata,
        output if_ready, if_rsp_valid, if_rdata, d_ready, d_rsp_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // Requester and memory side.
    modport master (
        output if_valid, if_addr, d_valid, d_addr, d_we, d_wdata, d_wstrb, mem_rdata,
        input  if_ready, if_rsp_valid, if_rdata, d_ready, d_rsp_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data with a saturating data-streak counter
// that forces fetch through after MAX_DATA_BURST contested data grants.
module mem_arb_prio import mem_arb_pkg::*; #(
    parameter int unsigned MAX_DATA_BURST = DefaultMaxDataBurst
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_valid_i,
    input  logic d_valid_i,
    input  logic slot_open_i,
    input  logic accept_i,
    output logic win_if_o,
    output logic win_d_o
);

    localparam int unsigned StreakW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_BURST);

    logic [StreakW-1:0] streak_q, streak_d;
    logic               pick_d;

    always_comb begin
        pick_d   = d_valid_i && (!if_valid_i || (streak_q < StreakMax));
        win_d_o  = slot_open_i && pick_d;
        win_if_o = slot_open_i && if_valid_i && !pick_d;

        streak_d = streak_q;
        if (accept_i) begin
            if (win_if_o) begin
                streak_d = '0;
            end else if (if_valid_i && (streak_q < StreakMax)) begin
                // Only data grants that made fetch wait count toward the streak.
                streak_d = streak_q + StreakW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// tracking the owner of the in-flight access to route its response back.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_LATENCY    = 1,
    parameter int unsigned MAX_DATA_BURST = DefaultMaxDataBurst
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CntW  = $clog2(MEM_LATENCY + 1);
    localparam int unsigned StrbW = strb_width(DATA_WIDTH);

    logic [CntW-1:0]       cnt_q, cnt_d;
    owner_e                owner_q, owner_d;
    logic                  owner_we_q, owner_we_d;

    logic                  slot_open, win_if, win_d, accept, rsp_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, rsp_data;
    logic [StrbW-1:0]      mem_wstrb;

    // Gating the slot with reset keeps every ready and memory command low in reset.
    assign slot_open = rst_ni && (cnt_q <= CntW'(1));
    assign accept    = win_if || win_d;

    mem_arb_prio #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_prio (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_valid_i  (bus.if_valid),
        .d_valid_i   (bus.d_valid),
        .slot_open_i (slot_open),
        .accept_i    (accept),
        .win_if_o    (win_if),
        .win_d_o     (win_d)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (win_d) begin
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
            mem_wstrb = bus.d_wstrb;
        end else if (win_if) begin
            mem_addr  = bus.if_addr;
        end

        cnt_d      = cnt_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        if (accept) begin
            cnt_d      = CntW'(MEM_LATENCY);
            owner_d    = win_d ? OWNER_D : OWNER_IF;
            owner_we_d = win_d && bus.d_we;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end

        rsp_fire = rst_ni && (cnt_q == CntW'(1));
        rsp_data = owner_we_q ? '0 : bus.mem_rdata;
    end

    assign bus.if_ready     = win_if;
    assign bus.d_ready      = win_d;
    assign bus.mem_en       = accept;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.mem_wstrb    = mem_wstrb;
    assign bus.if_rsp_valid = rsp_fire && (owner_q == OWNER_IF);
    assign bus.d_rsp_valid  = rsp_fire && (owner_q == OWNER_D);
    assign bus.if_rdata     = bus.if_rsp_valid ? rsp_data : '0;
    assign bus.d_rdata      = bus.d_rsp_valid  ? rsp_data : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            owner_q    <= OWNER_IF;
            owner_we_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
        end
    end

endmodule
